// File: rtl/mod3_frame_tx_if.sv
// -----------------------------------------------------------------------------
// mod3_frame_tx_if
//   Bundles the word-in handshake and the serial-out stream of mod3_frame_tx.
//
//   Signals:
//     in_valid    payload word available (driven by the word source)
//     in_data     WIDTH-bit payload word, bit WIDTH-1 is transmitted first
//     in_ready    transmitter can accept a word this cycle
//     tx_ready    downstream consumes the current serial bit this cycle
//     dout        current serial bit
//     dout_valid  dout holds a valid frame bit
//     frame_start current bit is the payload MSB
//     frame_last  current bit is the final check bit c[0]
//
//   Modports:
//     master  the environment side (word source and bit sink)
//     slave   the transmitter side
// -----------------------------------------------------------------------------
interface mod3_frame_tx_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             tx_ready;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             frame_last;

  modport master (
    output in_valid,
    output in_data,
    output tx_ready,
    input  in_ready,
    input  dout,
    input  dout_valid,
    input  frame_start,
    input  frame_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  tx_ready,
    output in_ready,
    output dout,
    output dout_valid,
    output frame_start,
    output frame_last
  );

endinterface : mod3_frame_tx_if

// File: rtl/mod3_frame_tx.sv
// -----------------------------------------------------------------------------
// mod3_frame_tx
//   Serial transmitter for the mod-3 divisibility stream. A WIDTH-bit word is
//   taken over a valid/ready handshake and shifted out MSB-first, followed by
//   two check bits c[1], c[0] chosen so that the complete WIDTH+2-bit frame,
//   read as an unsigned MSB-first integer, is a multiple of 3.
//
//   Ports:
//     clk     clock
//     resetn  synchronous, active-low reset
//     bus     mod3_frame_tx_if.slave
//               in_valid/in_data/in_ready : word handshake
//               tx_ready                  : downstream consumes current bit
//               dout/dout_valid           : serial bit stream
//               frame_start/frame_last    : first / last bit markers
//
//   The remainder r tracks the value of the bits already sent modulo 3. Since
//   the frame value is 4*V + c and 4 = 1 (mod 3), picking c = (3 - r) mod 3
//   makes the frame divisible by 3.
//
//   All serial outputs decode registered state only. in_ready looks at
//   tx_ready only in CHK0, where the next word is taken on the same edge that
//   consumes the final check bit so frames can run back to back.
// -----------------------------------------------------------------------------
module mod3_frame_tx #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           resetn,
  mod3_frame_tx_if.slave bus
);

  // A 1-bit payload still needs a (degenerate) one-bit counter.
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CHK1 = 2'd2,
    ST_CHK0 = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Remainder update for one more bit: (2*rem + bit) mod 3. rem is never 3.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] mod3_step(input logic [1:0] rem, input logic bit_in);
    logic [1:0] res;
    case ({rem, bit_in})
      3'b000:  res = 2'd0;
      3'b001:  res = 2'd1;
      3'b010:  res = 2'd2;
      3'b011:  res = 2'd0;
      3'b100:  res = 2'd1;
      3'b101:  res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Check value that cancels the payload remainder: (3 - rem) mod 3.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] mod3_check(input logic [1:0] rem);
    logic [1:0] res;
    case (rem)
      2'd0:    res = 2'd0;
      2'd1:    res = 2'd2;
      2'd2:    res = 2'd1;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       r_q,     r_d;
  logic [1:0]       c_q,     c_d;

  logic             in_ready_s;
  logic             dout_s;
  logic             dout_valid_s;
  logic             frame_start_s;
  logic             frame_last_s;
  logic             accept_s;
  logic             xfer_s;
  logic [1:0]       r_next_s;

  // Output decode from the registered state (plus tx_ready for in_ready in CHK0).
  always_comb begin
    in_ready_s    = 1'b0;
    dout_s        = 1'b0;
    dout_valid_s  = 1'b0;
    frame_start_s = 1'b0;
    frame_last_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_s = 1'b1;
      end
      ST_DATA: begin
        dout_valid_s  = 1'b1;
        dout_s        = shift_q[WIDTH-1];
        frame_start_s = (cnt_q == CNT_TOP);
      end
      ST_CHK1: begin
        dout_valid_s = 1'b1;
        dout_s       = c_q[1];
      end
      ST_CHK0: begin
        dout_valid_s = 1'b1;
        dout_s       = c_q[0];
        frame_last_s = 1'b1;
        in_ready_s   = bus.tx_ready;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Handshake qualifiers; a word is never taken while reset is asserted.
  always_comb begin
    accept_s = bus.in_valid && in_ready_s && resetn;
    xfer_s   = dout_valid_s && bus.tx_ready;
    r_next_s = mod3_step(r_q, shift_q[WIDTH-1]);
  end

  // Next-state and datapath updates; everything holds unless a transfer or accept happens.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          shift_d = bus.in_data;
          cnt_d   = CNT_TOP;
          r_d     = 2'd0;
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          r_d     = r_next_s;
          shift_d = shift_q << 1;
          if (cnt_q == CNT_ZERO) begin
            // Last payload bit: r_next_s already includes it.
            c_d     = mod3_check(r_next_s);
            state_d = ST_CHK1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CHK1: begin
        if (xfer_s) begin
          state_d = ST_CHK0;
        end else begin
          state_d = ST_CHK1;
        end
      end
      ST_CHK0: begin
        if (xfer_s && accept_s) begin
          // Next frame starts immediately after the final check bit.
          shift_d = bus.in_data;
          cnt_d   = CNT_TOP;
          r_d     = 2'd0;
          state_d = ST_DATA;
        end else if (xfer_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CHK0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= CNT_ZERO;
      r_q     <= 2'd0;
      c_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      c_q     <= c_d;
    end
  end

  assign bus.in_ready    = in_ready_s && resetn;
  assign bus.dout        = dout_s;
  assign bus.dout_valid  = dout_valid_s;
  assign bus.frame_start = frame_start_s;
  assign bus.frame_last  = frame_last_s;

endmodule : mod3_frame_tx

// File: tb/tb_mod3_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_mod3_frame_tx
//   Scoreboard bench for mod3_frame_tx (WIDTH=8) plus a WIDTH=1 instance.
//   Accepted words are expanded arithmetically into their expected frame
//   (4*V + (3 - V mod 3) mod 3, MSB-first) and queued; a monitor pops one
//   entry per transfer and also runs an independent mod-3 checker on dout.
// -----------------------------------------------------------------------------
module tb_mod3_frame_tx;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  mod3_frame_tx_if #(.WIDTH(8)) bus8 ();
  mod3_frame_tx_if #(.WIDTH(1)) bus1 ();

  mod3_frame_tx #(.WIDTH(8)) dut8 (.clk(clk), .resetn(resetn), .bus(bus8));
  mod3_frame_tx #(.WIDTH(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  typedef struct packed {
    logic b;
    logic s;
    logic l;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_tx  = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference frame for one accepted 8-bit word.
  task automatic push_frame(input logic [7:0] w);
    longint v;
    longint c;
    longint f;
    exp_t   e;
    v = longint'(w);
    c = (3 - (v % 3)) % 3;
    f = v * 4 + c;
    for (int i = 9; i >= 0; i--) begin
      e.b = logic'((f >> i) & 1);
      e.s = (i == 9);
      e.l = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  initial begin
    exp_t       e;
    logic       prev_stall;
    logic [3:0] prev_out;
    logic [3:0] cur;
    int         rem_ref;
    prev_stall = 1'b0;
    prev_out   = 4'd0;
    rem_ref    = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        prev_stall = 1'b0;
        rem_ref    = 0;
      end else begin
        cur = {bus8.dout, bus8.dout_valid, bus8.frame_start, bus8.frame_last};
        if (prev_stall) check("stall_hold", cur, prev_out);
        if (bus8.dout_valid && bus8.tx_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_bit");
          end else begin
            e = exp_q.pop_front();
            check("dout", bus8.dout, e.b);
            check("frame_start", bus8.frame_start, e.s);
            check("frame_last", bus8.frame_last, e.l);
            check("in_ready_during_frame", bus8.in_ready, e.l);
            rem_ref = e.s ? int'(bus8.dout) : (2 * rem_ref + int'(bus8.dout)) % 3;
            if (e.l) check("mod3_divisible", rem_ref, 0);
          end
        end
        prev_stall = bus8.dout_valid && !bus8.tx_ready;
        prev_out   = cur;
        if (bus8.in_valid && bus8.in_ready) push_frame(bus8.in_data);
      end
    end
  end

  // Random downstream back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_tx) bus8.tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_word(input logic [7:0] w, input bit keep);
    int t;
    bit acc;
    t   = 0;
    acc = 1'b0;
    bus8.in_data  = w;
    bus8.in_valid = 1'b1;
    while (!acc && t < 300) begin
      @(negedge clk);
      acc = bus8.in_valid && bus8.in_ready;
      @(posedge clk);
      t++;
    end
    #1;
    if (!acc) fail_now("accept_timeout");
    if (!keep) begin
      bus8.in_valid = 1'b0;
      bus8.in_data  = 8'($urandom);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus8.dout_valid) && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit        p [0:15];
    int        run;
    int        t;
    bit        keep;
    logic [7:0] dir_words [0:3];

    p = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
          1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    dir_words = '{8'h05, 8'h07, 8'hFF, 8'h00};

    resetn        = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.in_data  = 8'd0;
    bus8.tx_ready = 1'b1;
    bus1.in_valid = 1'b0;
    bus1.in_data  = 1'b0;
    bus1.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_outputs8", {bus8.dout, bus8.dout_valid, bus8.frame_start, bus8.frame_last}, 4'b0000);
    check("rst_in_ready8", bus8.in_ready, 1);
    check("rst_outputs1", {bus1.dout, bus1.dout_valid, bus1.frame_start, bus1.frame_last}, 4'b0000);
    check("rst_in_ready1", bus1.in_ready, 1);

    // WIDTH=1, word 1: frame value 6 -> bits 1,1,0.
    @(posedge clk);
    #1;
    bus1.in_data  = 1'b1;
    bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    bus1.in_data  = 1'b0;
    @(negedge clk);
    check("w1_bit1", {bus1.dout, bus1.dout_valid, bus1.frame_start, bus1.frame_last}, 4'b1110);
    @(negedge clk);
    check("w1_bit2", {bus1.dout, bus1.dout_valid, bus1.frame_start, bus1.frame_last}, 4'b1100);
    @(negedge clk);
    check("w1_bit3", {bus1.dout, bus1.dout_valid, bus1.frame_start, bus1.frame_last}, 4'b0101);
    @(negedge clk);
    check("w1_idle", {bus1.dout_valid, bus1.in_ready}, 2'b01);
    @(posedge clk);
    #1;

    // Directed words with tx_ready held high; first also checks latency.
    for (int i = 0; i < 4; i++) begin
      send_word(dir_words[i], 1'b0);
      @(negedge clk);
      check("latency_first_bit", {bus8.dout_valid, bus8.frame_start, bus8.in_ready}, 3'b110);
      drain();
    end

    // Back-to-back 0x05 then 0x07: 20 contiguous valid bits.
    run = 0;
    fork
      begin
        send_word(8'h05, 1'b1);
        send_word(8'h07, 1'b0);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!bus8.dout_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        while (bus8.dout_valid && run < 40) begin
          run++;
          @(negedge clk);
        end
      end
    join
    check("b2b_contiguous_bits", run, 20);
    drain();

    // Stalls of 3 cycles in DATA and in CHK1.
    send_word(8'h05, 1'b0);
    for (int i = 0; i < 16; i++) begin
      bus8.tx_ready = p[i];
      @(posedge clk);
      #1;
    end
    bus8.tx_ready = 1'b1;
    drain();

    // Reset after 4 bits of 0x05, then a clean 0x07 frame.
    send_word(8'h05, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("midreset_valid", bus8.dout_valid, 0);
    check("midreset_in_ready", bus8.in_ready, 1);
    @(posedge clk);
    #1;
    send_word(8'h07, 1'b0);
    drain();

    // Random words, random gaps, random back-pressure.
    rand_tx = 1'b1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      keep = (i != 59) && ($urandom_range(0, 1) == 1);
      send_word(8'($urandom), keep);
    end
    rand_tx = 1'b0;
    @(posedge clk);
    #1;
    bus8.tx_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mod3_frame_tx
